fetch_queue: RTL and testbench



---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_queue.sv | 84 ++++++++
 tb/tb_fetch_queue.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, fetch entry layout and debug encodings
package cpu_pkg;

  localparam int XLEN = 32;

  // Canonical RISC-V NOP (addi x0, x0, 0), used when displaying empty slots
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - first-word-fall-through instruction buffer between Fetch and Decode
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enq_valid,
  input  logic [XLEN-1:0]  enq_instr,
  input  logic [XLEN-1:0]  enq_pc,
  output logic             enq_ready,
  input  logic             fetch_complete,
  output logic             deq_valid,
  output logic [XLEN-1:0]  deq_instr,
  output logic [XLEN-1:0]  deq_pc,
  input  logic             deq_ready,
  input  logic             flush,
  output logic [PTR_W:0]   count,
  output logic             drained
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             drained_q, drained_d;
  logic             enq_fire, deq_fire;

  // Full is judged on count_q only, so deq_ready never reaches enq_ready
  assign enq_ready = (count_q != FULL_COUNT) & ~flush;
  assign deq_valid = (count_q != '0);
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;
  assign deq_instr = mem_q[head_q].instr;
  assign deq_pc    = mem_q[head_q].pc;
  assign count     = count_q;
  assign drained   = drained_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + PTR_W'(1);
      if (deq_fire) head_d = head_q + PTR_W'(1);
      count_d = count_q + {{PTR_W{1'b0}}, enq_fire} - {{PTR_W{1'b0}}, deq_fire};
    end
    drained_d = fetch_complete & (count_d == '0) & ~flush;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      drained_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      drained_q <= drained_d;
    end
  end

  // Storage is deliberately left uninitialised by reset
  always_ff @(posedge clk) begin
    if (reset_n && enq_fire) begin
      mem_q[tail_q] <= '{pc: enq_pc, instr: enq_instr};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enq_valid = 1'b0;
  logic [XLEN-1:0]   enq_instr = '0;
  logic [XLEN-1:0]   enq_pc = '0;
  logic              enq_ready;
  logic              fetch_complete = 1'b0;
  logic              deq_valid;
  logic [XLEN-1:0]   deq_instr;
  logic [XLEN-1:0]   deq_pc;
  logic              deq_ready = 1'b0;
  logic              flush = 1'b0;
  logic [PTR_W:0]    count;
  logic              drained;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_instr(enq_instr), .enq_pc(enq_pc), .enq_ready(enq_ready),
    .fetch_complete(fetch_complete),
    .deq_valid(deq_valid), .deq_instr(deq_instr), .deq_pc(deq_pc), .deq_ready(deq_ready),
    .flush(flush), .count(count), .drained(drained)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (!(reset_n && enq_valid && fetch_complete))
      else $error("protocol: enqueue offered after fetch_complete");
  end

  typedef struct {
    bit          ev;
    logic [31:0] pc;
    bit          dr;
    int          exp_count;
  } vec_t;

  vec_t         tbl[$];
  fetch_entry_t sb[$];
  int           m_count;
  bit           m_drained;
  int           total = 0;
  int           bad = 0;

  function automatic logic [31:0] instr_of(logic [31:0] pc);
    return 32'h00100093 + (pc >> 2);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(bit ev, logic [31:0] pc, bit dr, int exp_count);
    vec_t v;
    v.ev = ev; v.pc = pc; v.dr = dr; v.exp_count = exp_count;
    tbl.push_back(v);
  endtask

  // One clock: drive, check mid-cycle against the model, advance model, check count after edge
  task automatic cyc(bit rst, bit ev, logic [31:0] pc, bit dr, bit fl, bit fc, int exp_count);
    bit exp_rdy, en_f, de_f;
    fetch_entry_t e;
    reset_n = !rst; enq_valid = ev; enq_pc = pc; enq_instr = instr_of(pc);
    deq_ready = dr; flush = fl; fetch_complete = fc;
    @(negedge clk);
    exp_rdy = (m_count != DEPTH) && !fl;
    check("count", 32'(count), 32'(m_count));
    check("deq_valid", 32'(deq_valid), 32'(m_count != 0));
    check("enq_ready", 32'(enq_ready), 32'(exp_rdy));
    check("drained", 32'(drained), 32'(m_drained));
    if (m_count != 0 && sb.size() != 0) begin
      check("deq_pc", deq_pc, sb[0].pc);
      check("deq_instr", deq_instr, sb[0].instr);
    end
    en_f = ev && exp_rdy;
    de_f = dr && (m_count != 0);
    if (rst || fl) begin
      sb.delete();
      m_count = 0;
      m_drained = 1'b0;
    end else begin
      if (de_f) void'(sb.pop_front());
      if (en_f) begin
        e.pc = pc; e.instr = instr_of(pc);
        sb.push_back(e);
      end
      m_count = m_count + int'(en_f) - int'(de_f);
      m_drained = fc && (m_count == 0);
    end
    @(posedge clk);
    #1;
    check("count_after_edge", 32'(count), 32'(exp_count));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) add(1'b1, 32'(4*i), 1'b0, i+1);
    add(1'b1, 32'd32, 1'b0, 8);
    add(1'b1, 32'd32, 1'b1, 7);
    add(1'b1, 32'd32, 1'b1, 7);
    add(1'b1, 32'd36, 1'b1, 7);
    add(1'b1, 32'd40, 1'b1, 7);
    add(1'b1, 32'd44, 1'b1, 7);
    for (int i = 0; i < 7; i++) add(1'b0, 32'd0, 1'b1, 6-i);
    add(1'b0, 32'd0, 1'b1, 0);
    for (int i = 0; i < 3; i++) add(1'b1, 32'(48+4*i), 1'b0, i+1);
    for (int i = 0; i < 5; i++) add(1'b1, 32'(60+4*i), 1'b1, 3);

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_count = 0; m_drained = 1'b0; sb.delete();
    cyc(0, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) cyc(0, tbl[i].ev, tbl[i].pc, tbl[i].dr, 0, 0, tbl[i].exp_count);

    cyc(0, 1, 32'd80, 0, 0, 0, 4);
    cyc(0, 1, 32'd84, 0, 0, 0, 5);
    cyc(0, 1, 32'd88, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'd88, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 0);

    cyc(0, 1, 32'd100, 0, 0, 0, 1);
    cyc(0, 1, 32'd104, 0, 0, 0, 2);
    cyc(0, 1, 32'd108, 0, 0, 0, 3);
    cyc(0, 0, 0, 1, 0, 1, 2);
    cyc(0, 0, 0, 1, 0, 1, 1);
    cyc(0, 0, 0, 1, 0, 1, 0);
    check("drained_after_last_deq", 32'(drained), 32'd1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);

    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'd200, 0, 0, 0, 1);
    cyc(0, 1, 32'd204, 0, 0, 0, 2);
    cyc(0, 1, 32'd208, 0, 0, 0, 3);
    cyc(1, 1, 32'd212, 1, 0, 0, 0);
    check("drained_after_reset", 32'(drained), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'd300, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
